// File: rtl/cache_ctrl_pkg_41.sv
// rtl/cache_ctrl_pkg_41.sv - shared widths, FSM state type and line-align helper for cache_ctrl_41
package cache_ctrl_pkg_41;

  localparam int ADDR_W   = 31;
  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 6;
  localparam int WAYS     = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAY_W    = $clog2(WAYS);
  localparam int CNT_W    = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_RESP,
    S_FLUSH
  } state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_tag_store_41.sv
// rtl/cache_tag_store_41.sv - tag/valid/round-robin arrays with combinational lookup and victim choice
module cache_tag_store_41
  import cache_ctrl_pkg_41::*;
(
  input  logic               clk_41,
  input  logic               rst_41,
  input  logic [INDEX_W-1:0] lk_index,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_hit,
  output logic [WAY_W-1:0]   victim_way,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WAY_W-1:0]   wr_way,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               clr_en,
  input  logic [INDEX_W-1:0] clr_index
);

  localparam int SETS = 1 << INDEX_W;

  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];

  // The pointer only moves when a full set is refilled, i.e. when it was the victim.
  always_ff @(posedge clk_41 or negedge rst_41) begin
    if (!rst_41) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (clr_en) begin
      valid_q[clr_index] <= '0;
      rr_q[clr_index]    <= '0;
    end else if (wr_en) begin
      valid_q[wr_index][wr_way] <= 1'b1;
      if (&valid_q[wr_index])
        rr_q[wr_index] <= rr_q[wr_index] + 1'b1;
    end
  end

  always_ff @(posedge clk_41) begin
    if (wr_en)
      tag_mem[wr_index][wr_way] <= wr_tag;
  end

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    lk_hit     = 1'b0;
    victim_way = rr_q[lk_index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_index][w] && tag_mem[lk_index][w] == lk_tag)
        lk_hit = 1'b1;
      if (!valid_q[lk_index][w])
        victim_way = WAY_W'(w);
    end
  end

endmodule

// File: rtl/cache_ctrl_41.sv
// rtl/cache_ctrl_41.sv - request sequencing FSM, refill handshake and saturating hit/miss counters
module cache_ctrl_41
  import cache_ctrl_pkg_41::*;
(
  input  logic              clk_41,
  input  logic              rst_41,
  input  logic              req_valid_41,
  input  logic [ADDR_W-1:0] req_addr_41,
  output logic              req_ready_41,
  output logic              resp_valid_41,
  output logic              resp_hit_41,
  output logic              mem_req_41,
  output logic [ADDR_W-1:0] mem_addr_41,
  input  logic              mem_ack_41,
  input  logic              flush_41,
  output logic [CNT_W-1:0]  hits_41,
  output logic [CNT_W-1:0]  misses_41
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               hit_q;
  logic [INDEX_W-1:0] flush_idx_q;
  logic [CNT_W-1:0]   hits_q, misses_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               lk_hit;
  logic [WAY_W-1:0]   victim_way;
  logic               wr_en;

  assign idx   = addr_q[OFFSET_W +: INDEX_W];
  assign tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign wr_en = (state_q == S_REFILL) && mem_ack_41;

  cache_tag_store_41 u_tag_store (
    .clk_41     (clk_41),
    .rst_41     (rst_41),
    .lk_index   (idx),
    .lk_tag     (tag),
    .lk_hit     (lk_hit),
    .victim_way (victim_way),
    .wr_en      (wr_en),
    .wr_index   (idx),
    .wr_way     (victim_way),
    .wr_tag     (tag),
    .clr_en     (state_q == S_FLUSH),
    .clr_index  (flush_idx_q)
  );

  always_ff @(posedge clk_41 or negedge rst_41) begin
    if (!rst_41) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (flush_41) state_d = S_FLUSH;
                else if (req_valid_41) state_d = S_LOOKUP;
      S_LOOKUP: state_d = lk_hit ? S_RESP : S_REFILL;
      S_REFILL: if (mem_ack_41) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      S_FLUSH:  if (flush_idx_q == '1) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_41  = (state_q == S_IDLE) && !flush_41;
    resp_valid_41 = (state_q == S_RESP);
    resp_hit_41   = (state_q == S_RESP) && hit_q;
    mem_req_41    = (state_q == S_REFILL);
    mem_addr_41   = (state_q == S_REFILL) ? line_align(addr_q) : '0;
  end

  // Flush index wraps back to zero on its last step, ready for the next flush.
  always_ff @(posedge clk_41 or negedge rst_41) begin
    if (!rst_41) begin
      addr_q      <= '0;
      hit_q       <= 1'b0;
      flush_idx_q <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid_41 && req_ready_41)
        addr_q <= req_addr_41;
      if (state_q == S_LOOKUP)
        hit_q <= lk_hit;
      if (state_q == S_FLUSH)
        flush_idx_q <= flush_idx_q + 1'b1;
      if (state_q == S_RESP) begin
        if (hit_q) begin
          if (hits_q != CNT_MAX) hits_q <= hits_q + 1'b1;
        end else begin
          if (misses_q != CNT_MAX) misses_q <= misses_q + 1'b1;
        end
      end
    end
  end

  assign hits_41   = hits_q;
  assign misses_41 = misses_q;

endmodule

// File: tb/tb_cache_ctrl_41.sv
// tb/tb_cache_ctrl_41.sv - directed self-checking bench for cache_ctrl_41
module tb_cache_ctrl_41;

  logic        clk_41 = 1'b0;
  logic        rst_41;
  logic        req_valid_41;
  logic [30:0] req_addr_41;
  logic        req_ready_41;
  logic        resp_valid_41;
  logic        resp_hit_41;
  logic        mem_req_41;
  logic [30:0] mem_addr_41;
  logic        mem_ack_41;
  logic        flush_41;
  logic [30:0] hits_41;
  logic [30:0] misses_41;

  int total = 0;
  int bad   = 0;

  cache_ctrl_41 dut (
    .clk_41        (clk_41),
    .rst_41        (rst_41),
    .req_valid_41  (req_valid_41),
    .req_addr_41   (req_addr_41),
    .req_ready_41  (req_ready_41),
    .resp_valid_41 (resp_valid_41),
    .resp_hit_41   (resp_hit_41),
    .mem_req_41    (mem_req_41),
    .mem_addr_41   (mem_addr_41),
    .mem_ack_41    (mem_ack_41),
    .flush_41      (flush_41),
    .hits_41       (hits_41),
    .misses_41     (misses_41)
  );

  always #5 clk_41 = ~clk_41;

  task automatic apply_reset();
    rst_41 = 1'b0;
    repeat (2) @(negedge clk_41);
    rst_41 = 1'b1;
    @(negedge clk_41);
  endtask

  // Accept one request, ack the refill ack_dly cycles after mem_req rises, return
  // once the controller is back in IDLE with its counters updated.
  task automatic do_access(input logic [30:0] a, input int ack_dly, output logic got_hit,
                           output int lat, output logic [30:0] maddr, output logic saw_req);
    int n;
    int rc;
    bit done;
    @(negedge clk_41);
    req_valid_41 = 1'b1;
    req_addr_41  = a;
    n = 0;
    while (!req_ready_41 && n < 100) begin
      @(negedge clk_41);
      n++;
    end
    @(posedge clk_41);
    #1 req_valid_41 = 1'b0;
    lat = 0; rc = 0; done = 0; got_hit = 0; saw_req = 0; maddr = '0;
    while (!done && lat < 200) begin
      @(negedge clk_41);
      lat++;
      mem_ack_41 = 1'b0;
      if (resp_valid_41) begin
        done    = 1;
        got_hit = resp_hit_41;
      end else if (mem_req_41) begin
        if (!saw_req) maddr = mem_addr_41;
        saw_req = 1;
        if (rc == ack_dly) mem_ack_41 = 1'b1;
        rc++;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL access_timeout addr=%h no response after %0d cycles", a, lat);
    end
    @(negedge clk_41);
  endtask

  task automatic test_reset();
    rst_41 = 1'b0;
    repeat (2) @(negedge clk_41);
    total++; if (req_ready_41 !== 1'b1)  begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready_41); end
    total++; if (resp_valid_41 !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid_41); end
    total++; if (resp_hit_41 !== 1'b0)   begin bad++; $display("FAIL rst_resp_hit got=%b exp=0", resp_hit_41); end
    total++; if (mem_req_41 !== 1'b0)    begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req_41); end
    total++; if (mem_addr_41 !== 31'h0)  begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr_41); end
    total++; if (hits_41 !== 31'd0)      begin bad++; $display("FAIL rst_hits got=%0d exp=0", hits_41); end
    total++; if (misses_41 !== 31'd0)    begin bad++; $display("FAIL rst_misses got=%0d exp=0", misses_41); end
    rst_41 = 1'b1;
    @(negedge clk_41);
  endtask

  task automatic test_cold_miss_hit();
    logic h; int lat; logic [30:0] ma; logic sr;
    apply_reset();
    do_access(31'h100, 2, h, lat, ma, sr);
    total++; if (ma !== 31'h100)      begin bad++; $display("FAIL cold_mem_addr got=%h exp=100", ma); end
    total++; if (h !== 1'b0)          begin bad++; $display("FAIL cold_hit got=%b exp=0", h); end
    total++; if (lat != 5)            begin bad++; $display("FAIL cold_latency got=%0d exp=5", lat); end
    total++; if (misses_41 !== 31'd1) begin bad++; $display("FAIL cold_misses got=%0d exp=1", misses_41); end
    do_access(31'h10C, 0, h, lat, ma, sr);
    total++; if (h !== 1'b1)          begin bad++; $display("FAIL same_line_hit got=%b exp=1", h); end
    total++; if (lat != 2)            begin bad++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    total++; if (sr !== 1'b0)         begin bad++; $display("FAIL hit_mem_req got=%b exp=0", sr); end
    total++; if (hits_41 !== 31'd1)   begin bad++; $display("FAIL hit_count got=%0d exp=1", hits_41); end
  endtask

  task automatic test_eviction();
    logic [30:0] addrs [7] = '{31'h0000, 31'h0400, 31'h0800, 31'h0C00, 31'h1000, 31'h0000, 31'h0800};
    logic        exp_h [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic h; int lat; logic [30:0] ma; logic sr;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      do_access(addrs[i], 0, h, lat, ma, sr);
      total++; if (h !== exp_h[i]) begin bad++; $display("FAIL evict_hit[%0d] addr=%h got=%b exp=%b", i, addrs[i], h, exp_h[i]); end
      if (!exp_h[i]) begin
        total++; if (lat != 3) begin bad++; $display("FAIL evict_min_latency[%0d] got=%0d exp=3", i, lat); end
      end
    end
    total++; if (misses_41 !== 31'd6) begin bad++; $display("FAIL evict_misses got=%0d exp=6", misses_41); end
    total++; if (hits_41 !== 31'd1)   begin bad++; $display("FAIL evict_hits got=%0d exp=1", hits_41); end
  endtask

  task automatic test_flush();
    int n;
    logic h; int lat; logic [30:0] ma; logic sr;
    @(negedge clk_41);
    flush_41     = 1'b1;
    req_valid_41 = 1'b1;
    req_addr_41  = 31'h0800;
    #1;
    total++; if (req_ready_41 !== 1'b0) begin bad++; $display("FAIL flush_beats_req ready got=%b exp=0", req_ready_41); end
    @(posedge clk_41);
    #1 flush_41 = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk_41);
      if (req_ready_41) break;
      n++;
    end
    req_valid_41 = 1'b0;
    total++; if (n != 64)             begin bad++; $display("FAIL flush_busy_cycles got=%0d exp=64", n); end
    total++; if (misses_41 !== 31'd6) begin bad++; $display("FAIL flush_misses got=%0d exp=6", misses_41); end
    total++; if (hits_41 !== 31'd1)   begin bad++; $display("FAIL flush_hits got=%0d exp=1", hits_41); end
    do_access(31'h0800, 0, h, lat, ma, sr);
    total++; if (h !== 1'b0)          begin bad++; $display("FAIL post_flush_hit got=%b exp=0", h); end
    total++; if (misses_41 !== 31'd7) begin bad++; $display("FAIL post_flush_misses got=%0d exp=7", misses_41); end
  endtask

  task automatic test_refill_stall();
    int n;
    bit ok_req, ok_addr, ok_ready, ok_resp;
    logic h; int lat; logic [30:0] ma; logic sr;
    apply_reset();
    @(negedge clk_41);
    req_valid_41 = 1'b1;
    req_addr_41  = 31'h2340;
    @(posedge clk_41);
    #1 req_valid_41 = 1'b0;
    n = 0;
    do begin @(negedge clk_41); n++; end while (!mem_req_41 && n < 20);
    ok_req = 1; ok_addr = 1; ok_ready = 1; ok_resp = 1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk_41);
      if (mem_req_41 !== 1'b1)        ok_req   = 0;
      if (mem_addr_41 !== 31'h2340)   ok_addr  = 0;
      if (req_ready_41 !== 1'b0)      ok_ready = 0;
      if (resp_valid_41 !== 1'b0)     ok_resp  = 0;
    end
    total++; if (!ok_req)   begin bad++; $display("FAIL stall_mem_req got=unstable exp=held 1"); end
    total++; if (!ok_addr)  begin bad++; $display("FAIL stall_mem_addr got=%h exp=2340", mem_addr_41); end
    total++; if (!ok_ready) begin bad++; $display("FAIL stall_ready got=1 seen exp=0"); end
    total++; if (!ok_resp)  begin bad++; $display("FAIL stall_resp_valid got=1 seen exp=0"); end
    mem_ack_41 = 1'b1;
    @(negedge clk_41);
    mem_ack_41 = 1'b0;
    total++; if (resp_valid_41 !== 1'b1 || resp_hit_41 !== 1'b0) begin bad++; $display("FAIL stall_resp got=%b/%b exp=1/0", resp_valid_41, resp_hit_41); end
    @(negedge clk_41);
    mem_ack_41 = 1'b1;
    ok_req = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_41);
      if (mem_req_41 !== 1'b0 || resp_valid_41 !== 1'b0 || req_ready_41 !== 1'b1) ok_req = 0;
    end
    mem_ack_41 = 1'b0;
    total++; if (!ok_req) begin bad++; $display("FAIL stray_ack got=activity exp=idle"); end
    total++; if (misses_41 !== 31'd1 || hits_41 !== 31'd0) begin bad++; $display("FAIL stray_ack_counts got=%0d/%0d exp=0/1", hits_41, misses_41); end
    do_access(31'h2348, 0, h, lat, ma, sr);
    total++; if (h !== 1'b1) begin bad++; $display("FAIL stall_line_installed got=%b exp=1", h); end
  endtask

  task automatic test_reset_mid_refill();
    int n;
    logic h; int lat; logic [30:0] ma; logic sr;
    apply_reset();
    do_access(31'h0500, 0, h, lat, ma, sr);
    do_access(31'h0500, 0, h, lat, ma, sr);
    @(negedge clk_41);
    req_valid_41 = 1'b1;
    req_addr_41  = 31'h0900;
    @(posedge clk_41);
    #1 req_valid_41 = 1'b0;
    n = 0;
    do begin @(negedge clk_41); n++; end while (!mem_req_41 && n < 20);
    total++; if (mem_req_41 !== 1'b1) begin bad++; $display("FAIL midrst_pre_req got=%b exp=1", mem_req_41); end
    #2 rst_41 = 1'b0;
    #1;
    total++; if (mem_req_41 !== 1'b0)    begin bad++; $display("FAIL midrst_mem_req got=%b exp=0", mem_req_41); end
    total++; if (resp_valid_41 !== 1'b0) begin bad++; $display("FAIL midrst_resp_valid got=%b exp=0", resp_valid_41); end
    total++; if (hits_41 !== 31'd0)      begin bad++; $display("FAIL midrst_hits got=%0d exp=0", hits_41); end
    total++; if (misses_41 !== 31'd0)    begin bad++; $display("FAIL midrst_misses got=%0d exp=0", misses_41); end
    @(negedge clk_41);
    rst_41 = 1'b1;
    do_access(31'h0900, 0, h, lat, ma, sr);
    total++; if (h !== 1'b0 || sr !== 1'b1) begin bad++; $display("FAIL midrst_remiss got=hit%b/req%b exp=hit0/req1", h, sr); end
    total++; if (misses_41 !== 31'd1)       begin bad++; $display("FAIL midrst_remiss_count got=%0d exp=1", misses_41); end
  endtask

  task automatic test_trace_loop();
    int wrong;
    logic h; int lat; logic [30:0] ma; logic sr;
    apply_reset();
    wrong = 0;
    for (int i = 0; i < 1000; i++) begin
      do_access(31'((i % 8) * 16 + 4), 0, h, lat, ma, sr);
      if (h !== (i >= 8)) wrong++;
    end
    total++; if (wrong != 0)            begin bad++; $display("FAIL trace_hit_pattern got=%0d wrong exp=0", wrong); end
    total++; if (misses_41 !== 31'd8)   begin bad++; $display("FAIL trace_misses got=%0d exp=8", misses_41); end
    total++; if (hits_41 !== 31'd992)   begin bad++; $display("FAIL trace_hits got=%0d exp=992", hits_41); end
    total++; if (hits_41 + misses_41 !== 31'd1000) begin bad++; $display("FAIL trace_sum got=%0d exp=1000", hits_41 + misses_41); end
  endtask

  initial begin
    rst_41       = 1'b0;
    req_valid_41 = 1'b0;
    req_addr_41  = '0;
    mem_ack_41   = 1'b0;
    flush_41     = 1'b0;
    test_reset();
    test_cold_miss_hit();
    test_eviction();
    test_flush();
    test_refill_stall();
    test_reset_mid_refill();
    test_trace_loop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
